// File: rtl/dyn_add_pkg.sv
// Shared types and helpers for the dynamic adder front end.
// Optional build macro used by the top: DYN_ADD_CHECK_EN (adds the err output).
package dyn_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width able to hold any wait count up to 1 + N (the BPC = 1 worst case).
  function automatic int unsigned lw_of(input int unsigned n);
    return $clog2(n + 32'd2);
  endfunction

  // One launch cycle plus the cycles the longest propagate run needs to settle.
  function automatic int unsigned wait_cycles(input int unsigned l, input int unsigned bpc);
    return 32'd1 + (l + bpc - 32'd1) / bpc;
  endfunction

endpackage

// File: rtl/RCA.sv
// Combinational N-bit ripple-carry adder; P exposes the per-bit propagate terms.
module RCA #(
  parameter int N = 32
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic [N-1:0] S,
  output logic         Cout,
  output logic [N-1:0] P
);

  logic [N:0] carry_s;

  // Bit-serial carry chain.
  always_comb begin
    carry_s    = {(N+1){1'b0}};
    carry_s[0] = Cin;
    P          = A ^ B;
    S          = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      S[i]         = P[i] ^ carry_s[i];
      carry_s[i+1] = (A[i] & B[i]) | (P[i] & carry_s[i]);
    end
    Cout = carry_s[N];
  end

endmodule

// File: rtl/prop_run_len.sv
// Combinational length of the longest contiguous run of 1s in an N-bit vector.
module prop_run_len
  import dyn_add_pkg::*;
#(
  parameter  int N  = 32,
  localparam int LW = lw_of(N)
) (
  input  logic [N-1:0]  vec,
  output logic [LW-1:0] run_len
);

  logic [LW-1:0] cur_s;
  logic [LW-1:0] best_s;

  // Single scan from LSB: extend or restart the current run, keep the best.
  always_comb begin
    cur_s  = {LW{1'b0}};
    best_s = {LW{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (vec[i]) begin
        cur_s = cur_s + LW'(1'b1);
      end else begin
        cur_s = {LW{1'b0}};
      end
      if (cur_s > best_s) begin
        best_s = cur_s;
      end else begin
        best_s = best_s;
      end
    end
    run_len = best_s;
  end

endmodule

// File: rtl/dyn_add_sequencer.sv
// Clocked front end of the dynamic adder: accepts operands, waits a run-length dependent
// number of cycles for the RCA to settle, then holds {Cout,S}. DYN_ADD_CHECK_EN adds err.
module dyn_add_sequencer
  import dyn_add_pkg::*;
#(
  parameter  int N   = 32,
  parameter  int BPC = 4,
  localparam int LW  = lw_of(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_a,
  input  logic [N-1:0]  in_b,
  input  logic          in_cin,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N:0]    out_sum,
  output logic [LW-1:0] out_lat
`ifdef DYN_ADD_CHECK_EN
  ,
  output logic          err
`endif
);

  state_e        state_r;
  logic [LW-1:0] cnt_r;
  logic [N-1:0]  a_r;
  logic [N-1:0]  b_r;
  logic          cin_r;

  logic [N-1:0]  rca_sum_s;
  logic          rca_cout_s;
  logic [N-1:0]  p_unused_s;
  logic [LW-1:0] run_len_s;
  logic [LW-1:0] wait_s;

  assign in_ready = (state_r == IDLE);

  // Wait length is taken from the incoming operands so it is ready on the accept edge.
  prop_run_len #(.N(N)) u_run (
    .vec     (in_a ^ in_b),
    .run_len (run_len_s)
  );

  assign wait_s = LW'(wait_cycles(32'(run_len_s), BPC));

  RCA #(.N(N)) u_rca (
    .A    (a_r),
    .B    (b_r),
    .Cin  (cin_r),
    .S    (rca_sum_s),
    .Cout (rca_cout_s),
    .P    (p_unused_s)
  );

`ifdef DYN_ADD_CHECK_EN
  logic [N:0] ref_sum_s;
  assign ref_sum_s = {1'b0, a_r} + {1'b0, b_r} + {{N{1'b0}}, cin_r};
`endif

  // Sequencer FSM with operand registers and registered result/latency outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= {LW{1'b0}};
      a_r       <= {N{1'b0}};
      b_r       <= {N{1'b0}};
      cin_r     <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= {(N+1){1'b0}};
      out_lat   <= {LW{1'b0}};
`ifdef DYN_ADD_CHECK_EN
      err       <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r     <= in_a;
            b_r     <= in_b;
            cin_r   <= in_cin;
            cnt_r   <= wait_s;
            out_lat <= wait_s;
            state_r <= WAIT;
          end
        end
        WAIT: begin
          cnt_r <= cnt_r - LW'(1'b1);
          if (cnt_r == LW'(1'b1)) begin
            out_sum   <= {rca_cout_s, rca_sum_s};
            out_valid <= 1'b1;
            state_r   <= DONE;
`ifdef DYN_ADD_CHECK_EN
            if ({rca_cout_s, rca_sum_s} != ref_sum_s) begin
              err <= 1'b1;
            end
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_r   <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dyn_add_sequencer.sv
// Self-checking bench for dyn_add_sequencer (N=8, BPC=2) with a queue-based scoreboard.
module tb_dyn_add_sequencer;

  localparam int N   = 8;
  localparam int BPC = 2;
  localparam int LW  = $clog2(N + 2);

  typedef struct packed {
    logic [N:0]    sum;
    logic [LW-1:0] lat;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  in_a = '0;
  logic [N-1:0]  in_b = '0;
  logic          in_cin = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [N:0]    out_sum;
  logic [LW-1:0] out_lat;
`ifdef DYN_ADD_CHECK_EN
  logic          err;
`endif

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  dyn_add_sequencer #(.N(N), .BPC(BPC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_lat   (out_lat)
`ifdef DYN_ADD_CHECK_EN
    ,
    .err       (err)
`endif
  );

  function automatic int run_len(input logic [N-1:0] v);
    int cur = 0;
    int best = 0;
    for (int i = 0; i < N; i++) begin
      cur = v[i] ? cur + 1 : 0;
      if (cur > best) best = cur;
    end
    return best;
  endfunction

  function automatic int wexp(input int l);
    return 1 + (l + BPC - 1) / BPC;
  endfunction

  // Drives one operation with out_ready high; pushes the model result at accept, pops at output.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin,
                        output logic ok, output int edges, output logic [N:0] sum,
                        output logic [LW-1:0] lat, output logic busy_rdy, output exp_t e);
    exp_t pe;
    int   guard;
    ok = 1'b0; edges = 0; sum = '0; lat = '0; busy_rdy = 1'b0; e = '0;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) return;
    pe.sum = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
    pe.lat = LW'(wexp(run_len(a ^ b)));
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
    sb_q.push_back(pe);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_a = N'($urandom); in_b = N'($urandom); in_cin = 1'($urandom);
    busy_rdy = in_ready;
    while (!out_valid && edges < 60) begin
      @(posedge clk);
      @(negedge clk);
      edges++;
      if (!out_valid) busy_rdy = busy_rdy | in_ready;
    end
    e = sb_q.pop_front();
    if (!out_valid) return;
    sum = out_sum;
    lat = out_lat;
    ok = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== '0 || out_lat !== '0) begin
      failures++;
      $display("FAIL reset_hold: rdy=%b vld=%b sum=%h lat=%0d required rdy=1 vld=0 sum=0 lat=0",
               in_ready, out_valid, out_sum, out_lat);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: rdy=%b vld=%b required rdy=1 vld=0", in_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    logic [N-1:0]  ta [6] = '{8'h00, 8'hFF, 8'h33, 8'hAA, 8'h80, 8'hFF};
    logic [N-1:0]  tb [6] = '{8'h00, 8'h00, 8'h00, 8'h55, 8'h00, 8'hFF};
    logic          tc [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [N:0]    ts [6] = '{9'h000, 9'h100, 9'h033, 9'h0FF, 9'h081, 9'h1FF};
    int            tw [6] = '{1, 5, 2, 5, 2, 1};
    logic ok, busy;
    int edges;
    logic [N:0] sum;
    logic [LW-1:0] lat;
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      run_op(ta[i], tb[i], tc[i], ok, edges, sum, lat, busy, e);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL basic_timeout[%0d]: out_valid not seen, required within budget", i);
      end
      checks++;
      if (sum !== ts[i]) begin
        failures++;
        $display("FAIL basic_sum[%0d]: got %h required %h", i, sum, ts[i]);
      end
      checks++;
      if (lat !== LW'(tw[i]) || edges !== tw[i]) begin
        failures++;
        $display("FAIL basic_lat[%0d]: out_lat=%0d edges=%0d required %0d", i, lat, edges, tw[i]);
      end
      checks++;
      if (busy !== 1'b0) begin
        failures++;
        $display("FAIL basic_busy_ready[%0d]: in_ready seen %b while busy, required 0", i, busy);
      end
    end
  endtask

  task automatic test_backpressure();
    exp_t pe;
    exp_t e;
    int edges;
    out_ready = 1'b0;
    pe.sum = 9'h0FF;
    pe.lat = LW'(wexp(run_len(8'h0F ^ 8'hF0)));
    in_a = 8'h0F; in_b = 8'hF0; in_cin = 1'b0; in_valid = 1'b1;
    sb_q.push_back(pe);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    edges = 0;
    while (!out_valid && edges < 60) begin
      @(posedge clk);
      @(negedge clk);
      edges++;
    end
    e = sb_q.pop_front();
    checks++;
    if (edges !== 5) begin
      failures++;
      $display("FAIL bp_latency: edges=%0d required 5", edges);
    end
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; in_a = N'($urandom); in_b = N'($urandom);
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_sum !== e.sum || out_lat !== e.lat || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold[%0d]: vld=%b sum=%h lat=%0d rdy=%b required vld=1 sum=%h lat=%0d rdy=0",
                 k, out_valid, out_sum, out_lat, in_ready, e.sum, e.lat);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: vld=%b rdy=%b required vld=0 rdy=1", out_valid, in_ready);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL bp_spurious[%0d]: out_valid=%b required 0", k, out_valid);
      end
    end
  endtask

  task automatic test_reset_midflight();
    in_a = 8'hFF; in_b = 8'h01; in_cin = 1'b0; in_valid = 1'b1;
    sb_q.push_back('{sum: 9'h100, lat: LW'(wexp(run_len(8'hFE)))});
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_lat !== '0) begin
      failures++;
      $display("FAIL midreset_async: vld=%b rdy=%b lat=%0d required vld=0 rdy=1 lat=0",
               out_valid, in_ready, out_lat);
    end
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== '0) begin
        failures++;
        $display("FAIL midreset_after[%0d]: vld=%b rdy=%b sum=%h required vld=0 rdy=1 sum=0",
                 k, out_valid, in_ready, out_sum);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic ok, busy;
    int edges;
    logic [N:0] sum;
    logic [LW-1:0] lat;
    exp_t e;
    logic [N-1:0] a, b;
    for (int i = 0; i < 300; i++) begin
      a = N'($urandom);
      if ($urandom_range(0, 1) == 1) b = ~a ^ N'($urandom_range(0, 255) & $urandom_range(0, 255));
      else b = N'($urandom);
      run_op(a, b, 1'($urandom), ok, edges, sum, lat, busy, e);
      checks++;
      if (!ok || sum !== e.sum || lat !== e.lat || edges !== int'(e.lat) || busy !== 1'b0) begin
        failures++;
        $display("FAIL b2b[%0d]: ok=%b sum=%h lat=%0d edges=%0d busy=%b required sum=%h lat=%0d",
                 i, ok, sum, lat, edges, busy, e.sum, e.lat);
      end
    end
`ifdef DYN_ADD_CHECK_EN
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL b2b_err: err=%b required 0", err);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_midflight();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
